prod_bcd_conv: RTL

//  Sequential binary-to-BCD converter placed directly downstream of demo_one (5x5 multiplier).

---
 rtl/prod_disp_pkg.sv | 17 +
 rtl/bcd_digit_adj.sv | 16 +
 rtl/prod_bcd_conv.sv | 104 ++++++++++
 3 files changed

// File: rtl/prod_disp_pkg.sv
// Shared definitions for the product display path: widths, converter FSM encoding
// and the double-dabble digit adjust constants.
package prod_disp_pkg;

    localparam int DEF_BIN_W  = 10;
    localparam int DEF_DIGITS = 4;

    localparam logic [3:0] BCD_ADJ_THR = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: one BCD digit, add 3 when the digit is 5 or more.
module bcd_digit_adj
    import prod_disp_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_comb begin
        q = d;
        if (d >= BCD_ADJ_THR) begin
            q = d + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/prod_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with a start/busy/done handshake feeding the display driver.
module prod_bcd_conv
    import prod_disp_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W - 1);

    conv_state_t state, state_nxt;

    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_adj;
    logic [BIN_W-1:0]       bin;
    logic [CNT_W-1:0]       cnt;
    logic [ACC_W+BIN_W-1:0] shifted;
    logic                   load;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (acc[4*g +: 4]),
            .q (acc_adj[4*g +: 4])
        );
    end

    // Adjust precedes the shift, so the final shift result is used unadjusted.
    always_comb begin
        shifted = {acc_adj, bin} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // busy/done are flopped from the next state so they come straight off registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            bin     <= '0;
            cnt     <= '0;
            bcd_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_nxt == SHIFT);
            done <= (state_nxt == DONE);
            if (load) begin
                acc <= '0;
                bin <= bin_in;
                cnt <= CNT_LOAD;
            end else if (state == SHIFT) begin
                {acc, bin} <= shifted;
                cnt        <= cnt - 1'b1;
                if (cnt == '0) begin
                    bcd_out <= shifted[ACC_W+BIN_W-1 -: ACC_W];
                end
            end
        end
    end

endmodule
